// File: rtl/register_file_4_pkg.sv
// register_file_4_pkg: shared widths and request record for register_file_4 and its arbiter.
package register_file_4_pkg;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] raddr_a;
        logic [ADDR_W-1:0] raddr_b;
    } rf_req_t;
endpackage

// File: rtl/register_file_4.sv
// register_file_4: 4 x 4-bit register file, two combinational read ports, one synchronous write port.
module register_file_4
    import register_file_4_pkg::*;
(
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_reg_read_0,
    input  logic [ADDR_W-1:0] i_reg_read_1,
    input  logic [ADDR_W-1:0] i_reg_write,
    input  logic [DATA_W-1:0] i_port_write,
    input  logic              i_write_enable,
    output logic [DATA_W-1:0] o_port_read_0,
    output logic [DATA_W-1:0] o_port_read_1
);
    logic [DATA_W-1:0] regs [1<<ADDR_W];

    always_ff @(posedge i_clk)
        if (i_write_enable) regs[i_reg_write] <= i_port_write;

    assign o_port_read_0 = regs[i_reg_read_0];
    assign o_port_read_1 = regs[i_reg_read_1];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; search starts one past the last granted index.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        o_gnt = '0;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(ptr) + k) % N;
            if (!found && i_req[c]) begin
                found    = 1'b1;
                o_gnt[c] = i_rst_n;
                idx      = PW'(c);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) ptr <= PW'(N - 1);
        else if (found) ptr <= idx;
endmodule

// File: rtl/register_file_4_arbiter.sv
// register_file_4_arbiter: shares register_file_4 among NUM_REQ requesters with round-robin grant
// and a registered, backpressured response slot per requester.
module register_file_4_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = register_file_4_pkg::DATA_W,
    parameter int ADDR_W  = register_file_4_pkg::ADDR_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ-1:0]        i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_waddr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_raddr_a,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_raddr_b,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic [NUM_REQ*DATA_W-1:0] o_rsp_data_a,
    output logic [NUM_REQ*DATA_W-1:0] o_rsp_data_b,
    output logic [ADDR_W-1:0]         o_rf_reg_read_0,
    output logic [ADDR_W-1:0]         o_rf_reg_read_1,
    output logic [ADDR_W-1:0]         o_rf_reg_write,
    output logic [DATA_W-1:0]         o_rf_port_write,
    output logic                      o_rf_write_enable,
    input  logic [DATA_W-1:0]         i_rf_port_read_0,
    input  logic [DATA_W-1:0]         i_rf_port_read_1
);
    import register_file_4_pkg::rf_req_t;

    rf_req_t                          reqs [NUM_REQ];
    rf_req_t                          sel;
    logic [NUM_REQ-1:0]               eligible;
    logic [NUM_REQ-1:0]               gnt;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0]   data_a;
    logic [NUM_REQ-1:0][DATA_W-1:0]   data_b;

    // A slot that is draining this cycle can take a new request.
    assign eligible = i_req_valid & (~rsp_valid | i_rsp_ready);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (eligible),
        .o_gnt   (gnt)
    );

    always_comb begin
        sel = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            reqs[r] = '{we:      i_req_we[r],
                        waddr:   i_req_waddr[r*ADDR_W +: ADDR_W],
                        wdata:   i_req_wdata[r*DATA_W +: DATA_W],
                        raddr_a: i_req_raddr_a[r*ADDR_W +: ADDR_W],
                        raddr_b: i_req_raddr_b[r*ADDR_W +: ADDR_W]};
            if (gnt[r]) sel = reqs[r];
        end
    end

    assign o_req_ready       = gnt;
    assign o_rf_reg_read_0   = sel.raddr_a;
    assign o_rf_reg_read_1   = sel.raddr_b;
    assign o_rf_reg_write    = sel.waddr;
    assign o_rf_port_write   = sel.wdata;
    assign o_rf_write_enable = sel.we;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            rsp_valid <= '0;
            data_a    <= '0;
            data_b    <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++)
                if (gnt[r]) begin
                    rsp_valid[r] <= 1'b1;
                    data_a[r]    <= i_rf_port_read_0;
                    data_b[r]    <= i_rf_port_read_1;
                end else if (i_rsp_ready[r]) begin
                    rsp_valid[r] <= 1'b0;
                end
        end

    assign o_rsp_valid  = rsp_valid;
    assign o_rsp_data_a = data_a;
    assign o_rsp_data_b = data_b;
endmodule
